// File: rtl/telem_pkg.sv
// Shared types and constants for the ultrasonic telemetry framer.
// crc8_byte serves the TELEM_CRC8_EN build of telem_check.
package telem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int         FRAME_LEN      = 11;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY      = 8'h07;

  // MSB-first CRC-8, init and final XOR handled by the caller (both zero here).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/telem_check.sv
// Check-byte accumulator over frame bytes 1-9: plain XOR by default,
// CRC-8 (poly 0x07) when TELEM_CRC8_EN is defined.
module telem_check
  import telem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       upd_i,
  input  logic [7:0] data_i,
  output logic [7:0] value_o
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (upd_i) begin
`ifdef TELEM_CRC8_EN
      acc_d = crc8_byte(acc_q, data_i);
`else
      acc_d = acc_q ^ data_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign value_o = acc_q;

endmodule

// File: rtl/telemetry_framer.sv
// Packs the right/left/middle ranger distances into an 11-byte frame and feeds
// the UART one byte per tx_dv/tx_done handshake. Check byte type set by TELEM_CRC8_EN.
module telemetry_framer
  import telem_pkg::*;
#(
  parameter int unsigned DIST_W      = 20,
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
  parameter int unsigned MIN_GAP_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIST_W-1:0] distR,
  input  logic [DIST_W-1:0] distL,
  input  logic [DIST_W-1:0] distM,
  input  logic              endR,
  input  logic              endL,
  input  logic              endM,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic              frame_busy,
  output logic [7:0]        drop_cnt,
  output state_e            dbg_state
);

  localparam int         GAP_W    = (MIN_GAP_CYC > 1) ? $clog2(MIN_GAP_CYC) : 1;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  // Handshake: tx_dv is a one-cycle strobe with tx_byte valid in that cycle; the
  // next byte is offered only after tx_done is seen in WAIT_DONE and tx_active is low.
  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [2:0]        flags_q, flags_d;
  logic [7:0]        drop_q, drop_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [23:0]       snap_r_q, snap_l_q, snap_m_q;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        cur_byte, chk_val;
  logic [2:0]        ends, dup;
  logic [8:0]        drop_sum;
  logic              snap, load, chk_upd;

  assign ends = {endR, endL, endM};
  assign snap = (state_q == IDLE) && (&flags_q) && (gap_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (snap) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (!tx_active) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_dv      = 1'b0;
    load       = 1'b0;
    if ((state_q == LOAD) && !tx_active) begin
      tx_dv = 1'b1;
      load  = 1'b1;
    end
    frame_busy = (state_q != IDLE);
    dbg_state  = state_q;
  end

  always_comb begin
    case (idx_q)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = snap_r_q[23:16];
      4'd2:    cur_byte = snap_r_q[15:8];
      4'd3:    cur_byte = snap_r_q[7:0];
      4'd4:    cur_byte = snap_l_q[23:16];
      4'd5:    cur_byte = snap_l_q[15:8];
      4'd6:    cur_byte = snap_l_q[7:0];
      4'd7:    cur_byte = snap_m_q[23:16];
      4'd8:    cur_byte = snap_m_q[15:8];
      4'd9:    cur_byte = snap_m_q[7:0];
      default: cur_byte = chk_val;
    endcase
  end

  assign chk_upd   = load && (idx_q != 4'd0) && (idx_q < LAST_IDX);
  assign tx_byte_d = load ? cur_byte : tx_byte_q;
  assign tx_byte   = tx_byte_d;

  telem_check u_check (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (snap),
    .upd_i   (chk_upd),
    .data_i  (cur_byte),
    .value_o (chk_val)
  );

  // A strobe landing in the snapshot cycle re-arms its flag and is not a drop.
  assign flags_d  = (snap ? 3'b000 : flags_q) | ends;
  assign dup      = ends & flags_q & {3{~snap}};
  assign drop_sum = {1'b0, drop_q} + {8'b0, dup[2]} + {8'b0, dup[1]} + {8'b0, dup[0]};
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  assign drop_cnt = drop_q;

  always_comb begin
    gap_d = gap_q;
    if (snap)              gap_d = GAP_W'(MIN_GAP_CYC - 1);
    else if (gap_q != '0)  gap_d = gap_q - GAP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      flags_q   <= '0;
      drop_q    <= '0;
      gap_q     <= '0;
      snap_r_q  <= '0;
      snap_l_q  <= '0;
      snap_m_q  <= '0;
      tx_byte_q <= '0;
    end else begin
      idx_q     <= idx_d;
      flags_q   <= flags_d;
      drop_q    <= drop_d;
      gap_q     <= gap_d;
      tx_byte_q <= tx_byte_d;
      if (snap) begin
        snap_r_q <= 24'(distR);
        snap_l_q <= 24'(distL);
        snap_m_q <= 24'(distM);
      end
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a behavioural UART (10-cycle byte time).
// Build with TELEM_CRC8_EN to check the CRC-8 variant of the check byte.
module tb_telemetry_framer;
  import telem_pkg::*;

  localparam int W   = 20;
  localparam int GAP = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] distR = '0, distL = '0, distM = '0;
  logic         endR = 1'b0, endL = 1'b0, endM = 1'b0;
  logic         tx_active = 1'b0, tx_done = 1'b0;
  logic         tx_dv, frame_busy;
  logic [7:0]   tx_byte, drop_cnt;
  state_e       dbg_state;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;
  int           cyc = 0;
  logic [7:0]   cap_q[$];
  int           cyc_q[$];
  logic [7:0]   exp_q[$];

  telemetry_framer #(.DIST_W(W), .HEADER(8'hA5), .MIN_GAP_CYC(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .distR      (distR),
    .distL      (distL),
    .distM      (distM),
    .endR       (endR),
    .endL       (endL),
    .endM       (endM),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .frame_busy (frame_busy),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // ---- clock / reset ----
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // ---- behavioural UART: busy 10 cycles after tx_dv, then one tx_done ----
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      cap_q.push_back(tx_byte);
      cyc_q.push_back(cyc);
      @(posedge clk); #1 tx_active = 1'b1;
      repeat (10) @(posedge clk);
      #1 tx_active = 1'b0;
      tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
    end
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference forms of the check byte over the 9 payload bytes.
  function automatic logic [7:0] chk_model(input logic [71:0] msg);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
`ifdef TELEM_CRC8_EN
    for (int i = 71; i >= 0; i--) begin
      fb = c[7] ^ msg[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`else
    fb = 1'b0;
    for (int i = 0; i < 9; i++) c = c ^ msg[i*8 +: 8];
`endif
    return c;
  endfunction

  // ---- drivers ----
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic r, input logic l, input logic m);
    endR = r; endL = l; endM = m;
    @(posedge clk); #1;
    endR = 1'b0; endL = 1'b0; endM = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t;
    t = 0;
    while (cap_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_seen"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [23:0] r, input logic [23:0] l,
                              input logic [23:0] m, output int hdr_cyc, output logic [7:0] chk_got);
    logic [71:0] msg;
    logic [7:0]  got, exp_b, last_b;
    int          t;
    msg = {r, l, m};
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 8; i >= 0; i--) exp_q.push_back(msg[i*8 +: 8]);
    exp_q.push_back(chk_model(msg));
    wait_bytes(tag, 11);
    hdr_cyc = (cyc_q.size() > 0) ? cyc_q[0] : -1;
    got     = 8'h00;
    last_b  = 8'h00;
    for (int i = 0; i < 11; i++) begin
      got   = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
      if (cyc_q.size() > 0) void'(cyc_q.pop_front());
      exp_b = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_b));
      last_b = exp_b;
    end
    chk_got = got;
    t = 0;
    while (!tx_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_busy_at_last_done"}, 32'(frame_busy), 32'd1);
    check({tag, "_byte_held"}, 32'(tx_byte), 32'(last_b));
    @(negedge clk);
    check({tag, "_busy_after_last_done"}, 32'(frame_busy), 32'd0);
  endtask

  // ---- stimulus ----
  initial begin
    int         h1, h2, h_tmp;
    logic [7:0] c1, c_tmp;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_tx_dv",      32'(tx_dv),      32'd0);
    check("rst_tx_byte",    32'(tx_byte),    32'd0);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
    check("rst_state",      32'(dbg_state),  32'(IDLE));
    sync();
    rst_n = 1'b1;

    // Test 1 frame; Test 2 strobes land mid-frame, about 40 cycles after its header.
    sync();
    distR = 20'h12345; distL = 20'h00ABC; distM = 20'hFFFFF;
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    wait_bytes("t1_header", 1);
    repeat (40) @(posedge clk);
    #1;
    distR = 20'h00001;
    strobe(1'b1, 1'b0, 1'b0);
    distR = 20'hABCDE;
    strobe(1'b1, 1'b0, 1'b0);
    distL = 20'h54321; distM = 20'h0F0F0;
    strobe(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_drop_one", 32'(drop_cnt), 32'd1);

    expect_frame("t1", 24'h012345, 24'h000ABC, 24'h0FFFFF, h1, c1);
`ifndef TELEM_CRC8_EN
    check("t1_xor_hand", 32'(c1), 32'hDE);
`endif
    expect_frame("t2", 24'h0ABCDE, 24'h054321, 24'h00F0F0, h2, c_tmp);
    check("t3_gap_cycles", 32'(h2 - h1), 32'(GAP));

    // Drop counter saturation.
    sync();
    endR = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_drop_ten", 32'(drop_cnt), 32'd10);
    repeat (290) @(posedge clk);
    #1 endR = 1'b0;
    @(negedge clk);
    check("t2_drop_sat", 32'(drop_cnt), 32'hFF);
    check("t2_no_frame", 32'(frame_busy), 32'd0);

    sync();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
    sync();
    rst_n = 1'b1;

    // Test 4: endM in the snapshot cycle, distM changed mid-frame.
    sync();
    distR = 20'h11111; distL = 20'h22222; distM = 20'h33333;
    strobe(1'b0, 1'b0, 1'b1);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_drop_snapcycle", 32'(drop_cnt), 32'd0);
    wait_bytes("t4_header", 1);
    distM = 20'h44444;
    expect_frame("t4", 24'h011111, 24'h022222, 24'h033333, h_tmp, c_tmp);
    sync();
    strobe(1'b1, 1'b1, 1'b0);
    expect_frame("t4_fm_kept", 24'h011111, 24'h022222, 24'h044444, h_tmp, c_tmp);
    check("t4_drop_final", 32'(drop_cnt), 32'd0);

    // Test 5: reset while byte 4 is on the wire.
    sync();
    distR = 20'h0A0B0; distL = 20'hC0D0E; distM = 20'h0E0F0;
    strobe(1'b1, 1'b1, 1'b1);
    wait_bytes("t5_byte4", 5);
    sync();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_tx_dv",      32'(tx_dv),      32'd0);
    check("t5_rst_tx_byte",    32'(tx_byte),    32'd0);
    check("t5_rst_frame_busy", 32'(frame_busy), 32'd0);
    sync();
    rst_n = 1'b1;
    cap_q.delete();
    cyc_q.delete();
    repeat (300) @(negedge clk);
    check("t5_no_tx_after_rst", 32'(cap_q.size()), 32'd0);
    sync();
    strobe(1'b1, 1'b1, 1'b1);
    expect_frame("t5_resync", 24'h00A0B0, 24'h0C0D0E, 24'h00E0F0, h_tmp, c_tmp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
